// File: rtl/dmem_bridge.sv
// dmem_bridge: M-stage load/store to request/response data bus bridge with kseg0/kseg1 address mapping.
module dmem_bridge #(
  parameter int KSEG_MAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wen_q;
  logic [1:0]  size_q;
  logic        busy;
  assign busy = (state == REQ) || (state == WAIT);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= '0;
      size_q    <= '0;
      cpu_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cpu_en) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        wen_q   <= cpu_wen;
        size_q  <= cpu_size;
      end
      if (busy && data_data_ok) cpu_rdata <= data_rdata;
    end
  end
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (cpu_en ? REQ : IDLE) :
               (state == REQ)  ? (!data_addr_ok ? REQ : data_data_ok ? DONE : WAIT) :
               (state == WAIT) ? (data_data_ok ? DONE : WAIT) : IDLE;
  end
  // Bus fields come only from the holding registers so they stay stable while REQ waits.
  assign data_req   = (state == REQ);
  assign data_wr    = |wen_q;
  assign data_wstrb = wen_q;
  assign data_size  = size_q;
  assign data_wdata = wdata_q;
  assign data_addr  = (KSEG_MAP != 0 && addr_q[31:30] == 2'b10) ? {3'b000, addr_q[28:0]} : addr_q;
  assign cpu_stall  = cpu_en && (state != DONE);
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: scoreboard bench driving the bridge through load/store, wait, reset and back-to-back scenarios.
module tb_dmem_bridge;
  logic        clk, rst, cpu_en, addr_ok, data_ok;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, data_rdata;
  logic [31:0] cpu_rdata, data_addr, data_wdata, d0_rdata, d0_addr, d0_wdata;
  logic        cpu_stall, data_req, data_wr, d0_stall, d0_req, d0_wr;
  logic [1:0]  data_size, d0_size;
  logic [3:0]  data_wstrb, d0_wstrb;
  int          n_pass = 0, n_tot = 0, cyc = 0, n_stall = 0;
  bit          mon = 0;
  int          req_cyc[$];
  logic [31:0] sb[$];

  dmem_bridge #(.KSEG_MAP(1)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(addr_ok),
    .data_data_ok(data_ok), .data_rdata(data_rdata)
  );

  dmem_bridge #(.KSEG_MAP(0)) dut0 (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(d0_rdata), .cpu_stall(d0_stall),
    .data_req(d0_req), .data_wr(d0_wr), .data_size(d0_size), .data_addr(d0_addr),
    .data_wstrb(d0_wstrb), .data_wdata(d0_wdata), .data_addr_ok(addr_ok),
    .data_data_ok(data_ok), .data_rdata(data_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mon) begin
    if (cpu_stall) n_stall++;
    if (data_req) req_cyc.push_back(cyc);
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    @(posedge clk); #1;
    cpu_en = 0; addr_ok = 0; data_ok = 0; data_rdata = 32'hFFFF_FFFF;
  endtask

  // One full access: IDLE cycle, ad+1 REQ cycles, dd WAIT cycles, then DONE.
  task automatic access(input logic [3:0] wen, input logic [1:0] size,
                        input logic [31:0] addr, wdata, exp1, exp0,
                        input int ad, dd, input logic [31:0] rd);
    logic [31:0] e;
    if (wen == 4'b0000) sb.push_back(rd);
    @(posedge clk); #1;
    cpu_en = 1; cpu_wen = wen; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
    addr_ok = 0; data_ok = 0; data_rdata = 32'hFFFF_FFFF;
    #1; n_tot++;
    if (cpu_stall !== 1'b1 || data_req !== 1'b0)
      $display("FAIL idle_cycle addr=%h: stall=%b req=%b, required stall=1 req=0", addr, cpu_stall, data_req);
    else n_pass++;
    for (int i = 0; i <= ad; i++) begin
      @(posedge clk); #1;
      cpu_wen = ~wen; cpu_addr = ~addr; cpu_wdata = ~wdata;
      addr_ok = (i == ad); data_ok = (i == ad) && (dd == 0);
      data_rdata = data_ok ? rd : 32'hFFFF_FFFF;
      #1; n_tot++;
      if (data_req !== 1'b1 || cpu_stall !== 1'b1 || data_addr !== exp1 || d0_addr !== exp0 ||
          data_wstrb !== wen || data_wr !== (|wen) || data_size !== size || data_wdata !== wdata)
        $display("FAIL req_cycle%0d: req=%b stall=%b addr=%h addr0=%h strb=%b wr=%b size=%0d wdata=%h, required req=1 stall=1 addr=%h addr0=%h strb=%b wr=%b size=%0d wdata=%h",
                 i, data_req, cpu_stall, data_addr, d0_addr, data_wstrb, data_wr, data_size, data_wdata,
                 exp1, exp0, wen, |wen, size, wdata);
      else n_pass++;
    end
    for (int i = 1; i <= dd; i++) begin
      @(posedge clk); #1;
      addr_ok = 0; data_ok = (i == dd); data_rdata = data_ok ? rd : 32'hFFFF_FFFF;
      #1; n_tot++;
      if (data_req !== 1'b0 || cpu_stall !== 1'b1)
        $display("FAIL wait_cycle%0d: req=%b stall=%b, required req=0 stall=1", i, data_req, cpu_stall);
      else n_pass++;
    end
    @(posedge clk); #1;
    addr_ok = 0; data_ok = 0; data_rdata = 32'hFFFF_FFFF;
    #1; n_tot++;
    if (cpu_stall !== 1'b0 || data_req !== 1'b0)
      $display("FAIL done_cycle: stall=%b req=%b, required stall=0 req=0", cpu_stall, data_req);
    else n_pass++;
    if (wen == 4'b0000) begin
      e = sb.pop_front();
      n_tot++;
      if (cpu_rdata !== e) $display("FAIL load_data: rdata=%h, required %h", cpu_rdata, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 0; cpu_en = 0; cpu_wen = 0; cpu_size = 0; cpu_addr = 0; cpu_wdata = 0;
    addr_ok = 0; data_ok = 0; data_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1; n_tot++;
    if (data_req !== 0 || data_wr !== 0 || data_wstrb !== 0 || data_size !== 0 ||
        data_addr !== 0 || data_wdata !== 0 || cpu_rdata !== 0 || cpu_stall !== 0)
      $display("FAIL reset_outputs: req=%b wr=%b strb=%b size=%0d addr=%h wdata=%h rdata=%h stall=%b, required all 0",
               data_req, data_wr, data_wstrb, data_size, data_addr, data_wdata, cpu_rdata, cpu_stall);
    else n_pass++;
    cpu_en = 1;
    #1; n_tot++;
    if (cpu_stall !== 1'b1) $display("FAIL reset_stall: stall=%b, required 1", cpu_stall);
    else n_pass++;
    @(posedge clk); #1; n_tot++;
    if (data_req !== 1'b0) $display("FAIL reset_hold_idle: req=%b, required 0", data_req);
    else n_pass++;
    cpu_en = 0; rst = 1;
  endtask

  task automatic test_word_load();
    access(4'b0000, 2'd2, 32'h8000_1004, 32'h0, 32'h0000_1004, 32'h8000_1004, 0, 0, 32'hDEAD_BEEF);
    idle();
  endtask

  task automatic test_byte_store();
    access(4'b0100, 2'd0, 32'hA000_0002, 32'h00AB_0000, 32'h0000_0002, 32'hA000_0002, 3, 0, 32'h0);
    idle();
  endtask

  task automatic test_split();
    access(4'b0000, 2'd2, 32'h8000_0040, 32'h0, 32'h0000_0040, 32'h8000_0040, 0, 2, 32'h1234_5678);
    idle();
  endtask

  task automatic test_mapping();
    access(4'b0000, 2'd2, 32'h8000_0010, 32'h0, 32'h0000_0010, 32'h8000_0010, 1, 0, 32'hCAFE_0001);
    access(4'b0000, 2'd1, 32'h0040_0000, 32'h0, 32'h0040_0000, 32'h0040_0000, 0, 1, 32'hCAFE_0002);
    idle();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    cpu_en = 1; cpu_wen = 0; cpu_size = 2; cpu_addr = 32'h8000_0020; cpu_wdata = 0;
    @(posedge clk); #1;
    addr_ok = 1; data_ok = 0;
    @(posedge clk); #1;
    addr_ok = 0; rst = 0;
    #1; n_tot++;
    if (data_req !== 1'b0 || cpu_stall !== 1'b1)
      $display("FAIL mid_wait: req=%b stall=%b, required req=0 stall=1", data_req, cpu_stall);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1; cpu_en = 0;
    #1; n_tot++;
    if (data_req !== 0 || cpu_rdata !== 0 || data_addr !== 0 || cpu_stall !== 0)
      $display("FAIL mid_reset: req=%b rdata=%h addr=%h stall=%b, required all 0", data_req, cpu_rdata, data_addr, cpu_stall);
    else n_pass++;
    @(posedge clk); #1;
    data_ok = 1; data_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    data_ok = 0; data_rdata = 32'hFFFF_FFFF;
    #1; n_tot++;
    if (data_req !== 0 || cpu_rdata !== 0)
      $display("FAIL stale_data_ok: req=%b rdata=%h, required req=0 rdata=0", data_req, cpu_rdata);
    else n_pass++;
    access(4'b0000, 2'd2, 32'h0000_0100, 32'h0, 32'h0000_0100, 32'h0000_0100, 0, 0, 32'h5555_AAAA);
    idle();
  endtask

  task automatic test_back_to_back();
    n_stall = 0; req_cyc.delete(); mon = 1;
    access(4'b0000, 2'd2, 32'h8000_0200, 32'h0, 32'h0000_0200, 32'h8000_0200, 0, 0, 32'h0101_0101);
    access(4'b0000, 2'd2, 32'h8000_0204, 32'h0, 32'h0000_0204, 32'h8000_0204, 0, 0, 32'h0202_0202);
    idle();
    mon = 0;
    n_tot++;
    if (req_cyc.size() != 2 || req_cyc[1] - req_cyc[0] != 3)
      $display("FAIL b2b_req_spacing: pulses=%0d spacing=%0d, required pulses=2 spacing=3",
               req_cyc.size(), req_cyc.size() == 2 ? req_cyc[1] - req_cyc[0] : -1);
    else n_pass++;
    n_tot++;
    if (n_stall != 4) $display("FAIL b2b_stall_total: stall cycles=%0d, required 4", n_stall);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_split();
    test_mapping();
    test_reset_mid();
    test_back_to_back();
    n_tot++;
    if (sb.size() != 0) $display("FAIL scoreboard_left: entries=%0d, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter KSEG_MAP, default 1, meaning: 1 enables kseg0/kseg1 virtual-to-physical address mapping; 0 passes addresses unchanged.
REQ-002 Port clk, input, 1, meaning: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, meaning: synchronous reset, active-low.
REQ-004 Port cpu_en, input, 1, meaning: the M-stage instruction is a load or store.
REQ-005 Port cpu_wen, input, 4, meaning: byte write enables from the M stage; 4'b0000 means load.
REQ-006 Port cpu_size, input, 2, meaning: access size; 0 is byte, 1 is halfword, 2 is word.
REQ-007 Port cpu_addr, input, 32, meaning: virtual byte address, which is the M-stage ALU output.
REQ-008 Port cpu_wdata, input, 32, meaning: byte-lane-aligned store data.
REQ-009 Port cpu_rdata, output, 32, meaning: raw load word returned to the M stage.
REQ-010 Port cpu_stall, output, 1, meaning: freezes the pipeline while an access is outstanding.
REQ-011 Port data_req, output, 1, meaning: bus request valid.
REQ-012 Port data_wr, output, 1, meaning: 1 for a write request.
REQ-013 Port data_size, output, 2, meaning: bus access size.
REQ-014 Port data_addr, output, 32, meaning: physical byte address.
REQ-015 Port data_wstrb, output, 4, meaning: bus byte write strobes.
REQ-016 Port data_wdata, output, 32, meaning: bus write data.
REQ-017 Port data_addr_ok, input, 1, meaning: the slave accepts the request in this cycle.
REQ-018 Port data_data_ok, input, 1, meaning: read data is valid, or the write has completed, in this cycle.
REQ-019 Port data_rdata, input, 32, meaning: bus read data, valid when data_data_ok is 1.

Function
REQ-020 The FSM SHALL have four states: IDLE, REQ, WAIT and DONE.
REQ-021 IDLE SHALL move to REQ when cpu_en=1; on that edge it SHALL latch addr, wen, size and wdata into holding registers.
REQ-022 REQ SHALL drive data_req=1, with all bus fields taken from the holding registers.
- data_wr=|wen.
- data_wstrb=wen.
REQ-023 In REQ, when data_addr_ok=1 and data_data_ok=1 in the same cycle, the FSM SHALL move to DONE.
REQ-024 In REQ, when data_addr_ok=1 and data_data_ok=0, the FSM SHALL move to WAIT.
REQ-025 In REQ, when data_addr_ok=0, the FSM SHALL stay in REQ and hold every bus field stable.
REQ-026 WAIT SHALL drive data_req=0 and SHALL move to DONE when data_data_ok=1.
REQ-027 DONE SHALL move to IDLE unconditionally after one cycle.
REQ-028 data_rdata SHALL be captured into cpu_rdata on every cycle where data_data_ok=1 in REQ or WAIT.
- cpu_rdata SHALL hold its value otherwise.
- For writes the captured value is don't-care.
REQ-029 cpu_stall SHALL equal cpu_en AND (state != DONE).
- It is combinational, so it rises in the same cycle cpu_en rises.
REQ-030 Minimum access latency SHALL be 2 stall cycles: the IDLE cycle plus a REQ cycle in which both oks are 1; the stall deasserts in DONE.
REQ-031 Address mapping when KSEG_MAP=1 and cpu_addr[31:30]=2'b10 (kseg0 or kseg1): data_addr={3'b000, addr[28:0]}.
- Any other address SHALL pass through unchanged.
REQ-032 data_addr_ok and data_data_ok SHALL be ignored in IDLE and DONE.
REQ-033 A cpu_en that falls while the FSM is in REQ or WAIT SHALL NOT abort the transaction; the FSM completes it through DONE.
REQ-034 Back-to-back accesses: the next access SHALL start from IDLE.
- Each access therefore costs at least 3 cycles, including DONE.
- No request is issued in DONE.
REQ-035 data_req SHALL be 0 in every state except REQ.

Reset
REQ-036 When rst=0 at a rising edge, the FSM SHALL go to IDLE in any state, including REQ and WAIT.
REQ-037 The same reset SHALL clear the holding registers and cpu_rdata to 0.
REQ-038 After reset, data_req=0, data_wr=0, data_wstrb=0, data_size=0, data_addr=0 and data_wdata=0.
REQ-039 cpu_stall SHALL follow REQ-029 immediately after reset.
REQ-040 A data_data_ok that arrives after a mid-transaction reset SHALL be ignored.
- The slave is reset by the same rst.

Verification
REQ-041 Word load with zero-wait slave:
- Stimulus: cpu_en=1, wen=0, size=2, addr=0x80001004; addr_ok=1 and data_ok=1 in the first REQ cycle; rdata=0xDEADBEEF.
- Required: data_addr=0x00001004 and data_wr=0; cpu_stall=1 for 2 cycles, 0 in the third cycle; cpu_rdata=0xDEADBEEF.
REQ-042 Byte store with 3-cycle addr_ok delay:
- Stimulus: wen=4'b0100, size=0, addr=0xA0000002, wdata=0x00AB0000.
- Required: data_req held with stable fields for 4 REQ cycles; data_wstrb=4'b0100; data_addr=0x00000002.
REQ-043 Split response:
- Stimulus: addr_ok in REQ, data_ok 2 cycles later with rdata=0x12345678.
- Required: data_req=0 during WAIT; cpu_rdata=0x12345678 in DONE; stall deasserts in DONE.
REQ-044 KSEG_MAP=0 with addr=0x80000010 -> data_addr=0x80000010. KSEG_MAP=1 with addr=0x00400000 -> data_addr=0x00400000.
REQ-045 Reset mid-operation:
- Stimulus: rst=0 while in WAIT, then release rst and pulse data_ok.
- Required: state IDLE, data_req=0, cpu_rdata=0; the stale data_ok is ignored.
REQ-046 Two back-to-back loads with zero-wait slave -> two data_req pulses 3 cycles apart; total stall is 4 cycles.
